// File: rtl/keyboard_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : keyboard_uart_pkg
// Brief  : Shared types and helpers for the keyboard -> host serial link.
//          tx_state_t      : transmitter frame states
//          clks_per_bit()  : rounded system clocks per serial bit
//          baud_cnt_width(): width of the per-bit / stop-period counter
// Rev    : 1.0
// ============================================================================
package keyboard_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int BIT_IDX_W = 3;

  // Rounded to nearest so the bit period error stays below half a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // The counter must reach STOP_BITS*CLKS_PER_BIT-1 (longest timed period).
  function automatic int baud_cnt_width(input int clks, input int stop_bits);
    return (clks * stop_bits > 1) ? $clog2(clks * stop_bits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// ============================================================================
// Module : char_fifo
// Brief  : Synchronous FIFO with ready/valid push side and pop strobe.
//          clk, reset    : clock, synchronous active-high reset
//          push_valid    : producer offers push_data
//          push_data     : data word to store
//          push_ready    : registered, low while full (and during reset)
//          pop           : consume the head word (ignored when empty)
//          pop_data      : head word, valid while !empty
//          count         : words currently stored
//          empty         : no words stored
// Rev    : 1.0
// ============================================================================
module char_fifo
  import keyboard_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable
  // while both wrap naturally.
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr[AW-1:0]];
  assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // push_ready is registered from the next count so the upstream valid has
  // no combinational path back to ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      push_ready <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      push_ready <= (count_next != FULL_COUNT);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keyboard_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : keyboard_uart_tx
// Brief  : Buffers ASCII characters from the keyboard decoder and sends them
//          to the host as 8N1/8N2 async serial, gated by host CTS.
//          clk, reset      : clock, synchronous active-high reset
//          character_valid : upstream offers character_byte
//          character_byte  : character to send
//          character_ready : buffer can accept (registered)
//          cts             : host clear-to-send, asynchronous, active-high
//          tx              : serial line, idle high (registered)
//          fifo_count      : characters buffered
//          busy            : characters buffered or frame in progress
// Rev    : 1.0
// ============================================================================
module keyboard_uart_tx
  import keyboard_uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          character_valid,
  input  logic [7:0]                    character_byte,
  output logic                          character_ready,
  input  logic                          cts,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = baud_cnt_width(CPB, STOP_BITS);
  localparam logic [CNT_W-1:0]     BIT_LAST     = CNT_W'(CPB - 1);
  // STOP hands over to IDLE one cycle early: IDLE spends that cycle popping
  // the next character, so back-to-back frames keep exact stop-bit length.
  localparam logic [CNT_W-1:0]     STOP_HANDOFF = CNT_W'(STOP_BITS * CPB - 2);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX     = BIT_IDX_W'(7);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_cnt_next;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BIT_IDX_W-1:0] bit_idx_next;
  logic [7:0]           shift;
  logic [7:0]           shift_next;
  logic                 tx_next;
  logic                 pop;
  logic                 cts_meta;
  logic                 cts_sync;
  logic [7:0]           head;
  logic                 empty;

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (character_valid),
    .push_data  (character_byte),
    .push_ready (character_ready),
    .pop        (pop),
    .pop_data   (head),
    .count      (fifo_count),
    .empty      (empty)
  );

  assign busy = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
      cts_meta <= cts;
      cts_sync <= cts_meta;
    end
  end

  // tx_next is the line level for the cycle after this edge, so it follows
  // the state being entered rather than the current one.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    tx_next       = 1'b1;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (!empty && cts_sync) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
          tx_next       = shift[0];
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift[7:1]};
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            tx_next      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_cnt == STOP_HANDOFF) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keyboard_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_keyboard_uart_tx
// Brief  : Self-checking bench for keyboard_uart_tx (CLKS_PER_BIT=16,
//          FIFO_DEPTH=4). dut1 uses one stop bit, dut2 two stop bits.
// Rev    : 1.0
// ============================================================================
module tb_keyboard_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       v1, rdy1, cts1, tx1, busy1;
  logic [7:0] b1;
  logic [2:0] cnt1;
  logic       v2, rdy2, cts2, tx2, busy2;
  logic [7:0] b2;
  logic [2:0] cnt2;

  keyboard_uart_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst), .character_valid(v1), .character_byte(b1),
    .character_ready(rdy1), .cts(cts1), .tx(tx1), .fifo_count(cnt1), .busy(busy1));

  keyboard_uart_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst), .character_valid(v2), .character_byte(b2),
    .character_ready(rdy2), .cts(cts2), .tx(tx2), .fifo_count(cnt2), .busy(busy2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // UART monitor on dut1: decodes frames at bit centres
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  int         frame_err = 0;
  int         cnt_over = 0;
  bit         mon_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx1 === 1'b0) begin
        automatic int t0 = cyc;
        automatic logic [7:0] d = '0;
        repeat (CPB / 2 - 1) @(negedge clk);
        if (tx1 !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx1;
        end
        repeat (CPB) @(negedge clk);
        if (tx1 !== 1'b1) frame_err++;
        if (mon_en) begin
          rx_q.push_back(d);
          rx_t.push_back(t0);
        end
      end
    end
  end

  always @(negedge clk) if (!rst && cnt1 > 3'd4) cnt_over++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer b, hold valid until a ready edge; returns 1ns after the accepting edge.
  task automatic push1(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    v1 = 1'b1;
    b1 = b;
    while (!rdy1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy1) begin
      check("push1_ready_timeout", 32'(rdy1), 1);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(b);
    end
    v1 = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("rx_frame_count", rx_q.size(), n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] slots;   // bit k = expected tx level in bit period k (start first)
  } fvec_t;

  fvec_t vecs[6];
  logic  tx_s[400];
  logic  busy_s[400];
  bit    done;

  initial begin
    int n, mism, f1, r1, f2, r2, busy_cnt;

    vecs[0] = '{data: 8'h41, slots: 10'b1_01000001_0};
    vecs[1] = '{data: 8'h00, slots: 10'b1_00000000_0};
    vecs[2] = '{data: 8'hFF, slots: 10'b1_11111111_0};
    vecs[3] = '{data: 8'h55, slots: 10'b1_01010101_0};
    vecs[4] = '{data: 8'hA5, slots: 10'b1_10100101_0};
    vecs[5] = '{data: 8'h0D, slots: 10'b1_00001101_0};

    rst = 1'b1; v1 = 1'b0; b1 = '0; cts1 = 1'b1; v2 = 1'b0; b2 = '0; cts2 = 1'b1;
    tick(3);
    check("reset_tx", 32'(tx1), 1);
    check("reset_ready", 32'(rdy1), 0);
    check("reset_count", 32'(cnt1), 0);
    check("reset_busy", 32'(busy1), 0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    check("ready_after_reset", 32'(rdy1), 1);
    tick(3);

    // Single frames from the vector table
    for (int k = 0; k < 6; k++) begin
      push1(vecs[k].data);
      check($sformatf("v%0d_count_push", k), 32'(cnt1), 1);
      check($sformatf("v%0d_busy_push", k), 32'(busy1), 1);
      tick(1);
      check($sformatf("v%0d_tx_fall", k), 32'(tx1), 0);
      check($sformatf("v%0d_count_pop", k), 32'(cnt1), 0);
      for (int s = 0; s < 10; s++) begin
        tick(s == 0 ? 8 : 16);
        check($sformatf("v%0d_slot%0d", k, s), 32'(tx1), 32'(vecs[k].slots[s]));
      end
      tick(6);
      check($sformatf("v%0d_busy_159", k), 32'(busy1), 1);
      tick(1);
      check($sformatf("v%0d_busy_160", k), 32'(busy1), 0);
      check($sformatf("v%0d_tx_idle", k), 32'(tx1), 1);
    end

    // Six bytes with valid held: FIFO fills, frames back-to-back
    exp_q.delete(); rx_q.delete(); rx_t.delete(); mon_en = 1'b1;
    for (int i = 0; i < 5; i++) push1(8'h31 + 8'(i));
    check("full_ready", 32'(rdy1), 0);
    check("full_count", 32'(cnt1), 4);
    push1(8'h36);
    wait_rx(6, 2000);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), 32'(rx_q[i]), 32'(8'h31 + 8'(i)));
    for (int i = 1; i < 6 && i < rx_t.size(); i++)
      check($sformatf("b2b_spacing%0d", i), rx_t[i] - rx_t[i-1], 160);
    tick(20);

    // CTS gating
    exp_q.delete(); rx_q.delete(); rx_t.delete();
    @(negedge clk) cts1 = 1'b0;
    tick(4);
    push1(8'h61); push1(8'h62); push1(8'h63);
    tick(40);
    check("cts_low_tx", 32'(tx1), 1);
    check("cts_low_count", 32'(cnt1), 3);
    @(negedge clk) cts1 = 1'b1;
    n = 0;
    while (tx1 === 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check("cts_start_within3", 32'(n >= 1 && n <= 3), 1);
    tick(50);
    @(negedge clk) cts1 = 1'b0;
    tick(400);
    check("cts_drop_frames", rx_q.size(), 1);
    check("cts_drop_count", 32'(cnt1), 2);
    check("cts_drop_tx", 32'(tx1), 1);
    @(negedge clk) cts1 = 1'b1;
    wait_rx(3, 1000);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check($sformatf("cts_byte%0d", i), 32'(rx_q[i]), 32'(8'h61 + 8'(i)));
    tick(20);

    // Reset in the middle of data bit 3 (0x52: bit3 = 0)
    mon_en = 1'b0;
    push1(8'h52); push1(8'h11); push1(8'h22);
    tick(70);
    check("pre_reset_bit3", 32'(tx1), 0);
    check("pre_reset_count", 32'(cnt1), 2);
    @(negedge clk) rst = 1'b1;
    tick(1);
    check("midrst_tx", 32'(tx1), 1);
    check("midrst_count", 32'(cnt1), 0);
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_ready", 32'(rdy1), 0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    check("postrst_ready", 32'(rdy1), 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) n++;
    end
    check("postrst_quiet", n, 0);

    // Two stop bits: 0x00 then 0xFF on dut2
    @(negedge clk);
    check("dut2_ready", 32'(rdy2), 1);
    v2 = 1'b1; b2 = 8'h00;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (i == 0) b2 = 8'hFF;
      if (i == 1) v2 = 1'b0;
      tx_s[i] = tx2;
      busy_s[i] = busy2;
    end
    f1 = -1; r1 = -1; f2 = -1; r2 = -1; busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_s[i] === 1'b1) busy_cnt++;
      if (i > 0) begin
        if (f1 < 0 && tx_s[i-1] && !tx_s[i]) f1 = i;
        else if (f1 >= 0 && r1 < 0 && !tx_s[i-1] && tx_s[i]) r1 = i;
        else if (r1 >= 0 && f2 < 0 && tx_s[i-1] && !tx_s[i]) f2 = i;
        else if (f2 >= 0 && r2 < 0 && !tx_s[i-1] && tx_s[i]) r2 = i;
      end
    end
    check("stop2_first_fall", f1, 1);
    check("stop2_stop_start", r1, 145);
    check("stop2_gap", f2 - r1, 32);
    check("stop2_ff_start_len", r2 - f2, 16);
    check("stop2_busy_cycles", busy_cnt, 352);
    check("stop2_tx_end", 32'(tx_s[399]), 1);

    // Random valid gaps and CTS toggling with scoreboard
    exp_q.delete(); rx_q.delete(); rx_t.delete(); frame_err = 0;
    mon_en = 1'b1; done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 40)) @(negedge clk);
          push1(8'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          repeat ($urandom_range(1, 60)) @(negedge clk);
          cts1 = ($urandom_range(0, 3) != 0);
        end
        cts1 = 1'b1;
      end
    join
    wait_rx(exp_q.size(), 5000);
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    check("rand_byte_mismatches", mism, 0);
    check("rand_frame_errors", frame_err, 0);
    check("fifo_count_le4", cnt_over, 0);
    tick(20);
    check("rand_idle_busy", 32'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
